alu_param_sync: RTL and testbench

//  Parametrised synchronous ALU, successor to the fixed 4-bit ALU of the microcore datapath.
//  - Adds WIDTH-generic operands, status flags, shift ops and an async reset.
//  - Adds an optional iterative multiplier with a busy/ack handshake.
//  - Sits between the register file and the control FSM; the control FSM pulses enable and waits for alu_ack.

---
 rtl/alu_param_sync.sv | 139 +++++++++++++
 tb/tb_alu_param_sync.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_param_sync.sv
// alu_param_sync: WIDTH-generic registered ALU with status flags and a one-cycle ack.
// Define ALU_MUL_EN to add the iterative shift-add multiplier (sel 0011, busy, result_hi).
module alu_param_sync #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy,
  output logic             alu_ack
);
  logic [3:0]       w_op;
  logic [WIDTH:0]   w_add, w_sub;
  logic [WIDTH-1:0] w_res;
  logic             w_is_add, w_is_sub, w_bs, w_c, w_v;
  logic [WIDTH-1:0] r_result;
  logic             r_z, r_n, r_c, r_v, r_ack;
  always_comb begin
    w_op     = 4'(sel);
    w_is_add = w_op[3:2] == 2'b10;
    w_is_sub = w_op[3:2] == 2'b11;
    w_add    = {1'b0, a} + {1'b0, b};
    w_sub    = {1'b0, a} - {1'b0, b};
    w_res    = w_op == 4'b0100 ? a | b :
               w_op == 4'b0101 ? a & b :
               w_op == 4'b0110 ? a ^ b :
               w_op == 4'b0111 ? ~(a & b) :
               w_is_add ? w_add[WIDTH-1:0] :
               w_is_sub ? w_sub[WIDTH-1:0] :
               w_op == 4'b0001 ? a << b :
               w_op == 4'b0010 ? a >> b : '0;
    // overflow compares against the sign of the effective addend (-b for SUB)
    w_bs     = w_is_sub ? (((-b) >> (WIDTH - 1)) != '0) : b[WIDTH-1];
    w_c      = w_is_add ? w_add[WIDTH] : (w_is_sub & w_sub[WIDTH]);
    w_v      = (w_is_add | w_is_sub) & (a[WIDTH-1] == w_bs) & (w_res[WIDTH-1] != a[WIDTH-1]);
  end
`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;
  logic [0:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_ma, r_acc, w_acc_nx;
  logic [WIDTH-1:0]   r_mb, r_hi;
  logic               r_busy;
  assign w_acc_nx = r_acc + (r_mb[0] ? r_ma : '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ma     <= '0;
      r_mb     <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_busy   <= 1'b0;
      r_result <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_ack    <= 1'b0;
    end else if (r_state == S_MUL) begin
      r_acc <= w_acc_nx;
      r_ma  <= r_ma << 1;
      r_mb  <= r_mb >> 1;
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CW'(WIDTH - 1)) begin
        r_state  <= S_IDLE;
        r_busy   <= 1'b0;
        r_ack    <= 1'b1;
        r_result <= w_acc_nx[WIDTH-1:0];
        r_hi     <= w_acc_nx[2*WIDTH-1:WIDTH];
        r_z      <= w_acc_nx[WIDTH-1:0] == '0;
        r_n      <= w_acc_nx[WIDTH-1];
        r_c      <= 1'b0;
        r_v      <= 1'b0;
      end
    end else if (enable && w_op == 4'b0011) begin
      r_state <= S_MUL;
      r_busy  <= 1'b1;
      r_ack   <= 1'b0;
      r_ma    <= {{WIDTH{1'b0}}, a};
      r_mb    <= b;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (enable) begin
      r_ack    <= 1'b1;
      r_result <= w_res;
      r_hi     <= '0;
      r_z      <= w_res == '0;
      r_n      <= w_res[WIDTH-1];
      r_c      <= w_c;
      r_v      <= w_v;
    end else begin
      r_ack <= 1'b0;
    end
  end
  assign busy      = r_busy;
  assign result_hi = r_hi;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_ack    <= 1'b0;
    end else if (enable) begin
      r_ack    <= 1'b1;
      r_result <= w_res;
      r_z      <= w_res == '0;
      r_n      <= w_res[WIDTH-1];
      r_c      <= w_c;
      r_v      <= w_v;
    end else begin
      r_ack <= 1'b0;
    end
  end
  assign busy      = 1'b0;
  assign result_hi = '0;
`endif
  assign result  = r_result;
  assign flag_z  = r_z;
  assign flag_n  = r_n;
  assign flag_c  = r_c;
  assign flag_v  = r_v;
  assign alu_ack = r_ack;
endmodule

// File: tb/tb_alu_param_sync.sv
// tb_alu_param_sync: scoreboard bench driving a WIDTH=4 and a WIDTH=8 alu_param_sync.
`timescale 1ns/1ps
module tb_alu_param_sync;
  typedef struct packed {
    logic [7:0] res;
    logic [7:0] hi;
    logic [3:0] f;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst4_n = 1'b1, rst8_n = 1'b1;
  logic       en4 = 1'b0, en8 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, s4 = '0, s8 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] r4, h4;
  logic [7:0] r8, h8;
  logic       z4, n4, c4, v4, bz4, k4, z8, n8, c8, v8, bz8, k8;
  int         errs = 0, chks = 0, nb4 = 0, nb8 = 0;
  exp_t       q4[$], q8[$];
  exp_t       e4, e8;
`ifndef ALU_MUL_EN
  logic       saw_busy4 = 1'b0, saw_busy8 = 1'b0;
  always @(negedge clk) begin
    if (bz4) saw_busy4 = 1'b1;
    if (bz8) saw_busy8 = 1'b1;
  end
`endif
  always #5 clk = ~clk;
  alu_param_sync #(.WIDTH(4), .SEL_W(4)) u4 (
    .clk(clk), .rst_n(rst4_n), .enable(en4), .a(a4), .b(b4), .sel(s4),
    .result(r4), .result_hi(h4), .flag_z(z4), .flag_n(n4), .flag_c(c4), .flag_v(v4),
    .busy(bz4), .alu_ack(k4));
  alu_param_sync #(.WIDTH(8), .SEL_W(4)) u8 (
    .clk(clk), .rst_n(rst8_n), .enable(en8), .a(a8), .b(b8), .sel(s8),
    .result(r8), .result_hi(h8), .flag_z(z8), .flag_n(n8), .flag_c(c8), .flag_v(v8),
    .busy(bz8), .alu_ack(k8));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst4_n && k4) begin
      if (q4.size() == 0) begin
        chks++; errs++;
        $display("FAIL ack4_unexpected: got ack with result %h want no ack", r4);
      end else begin
        e4 = q4.pop_front();
        chk("out4 {hi,res,z,n,c,v}", {h4, r4, z4, n4, c4, v4}, {e4.hi[3:0], e4.res[3:0], e4.f});
      end
    end
    if (rst8_n && k8) begin
      if (q8.size() == 0) begin
        chks++; errs++;
        $display("FAIL ack8_unexpected: got ack with result %h want no ack", r8);
      end else begin
        e8 = q8.pop_front();
        chk("out8 {hi,res,z,n,c,v}", {h8, r8, z8, n8, c8, v8}, {e8.hi, e8.res, e8.f});
      end
    end
  end
  // f = {z,n,c,v}
  task automatic issue(input bit w8, input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic [7:0] h, input logic [3:0] f);
    if (w8) begin
      en8 = 1'b1; s8 = s; a8 = a; b8 = b; q8.push_back({r, h, f});
    end else begin
      en4 = 1'b1; s4 = s; a4 = a[3:0]; b4 = b[3:0]; q4.push_back({r, h, f});
    end
  endtask
  task automatic op(input bit w8, input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                    input logic [7:0] r, input logic [7:0] h, input logic [3:0] f);
    @(negedge clk);
    issue(w8, s, a, b, r, h, f);
  endtask
  task automatic idle(input bit w8);
    @(negedge clk);
    if (w8) en8 = 1'b0; else en4 = 1'b0;
  endtask
  task automatic wait_ack(input bit w8, input bit poke, output int nb);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (w8 ? k8 : k4) return;
      if (w8 ? bz8 : bz4) nb++;
      if (w8) begin
        en8 = poke && i == 1; s8 = 4'b1000;
      end else begin
        en4 = poke && i == 1; s4 = 4'b1000;
      end
    end
  endtask
  task automatic seq4();
    #1 rst4_n = 1'b0;
    #1 chk("reset4", {r4, h4, z4, n4, c4, v4, bz4, k4}, 0);
    @(negedge clk); @(negedge clk); rst4_n = 1'b1;
    op(0, 4'b1000, 9, 8, 1, 0, 4'b0011);
    op(0, 4'b1100, 3, 5, 14, 0, 4'b0110);
    op(0, 4'b1011, 7, 1, 8, 0, 4'b0101);
    op(0, 4'b1110, 5, 5, 0, 0, 4'b1000);
    op(0, 4'b0111, 15, 15, 0, 0, 4'b1000);
    op(0, 4'b0001, 3, 2, 12, 0, 4'b0100);
    op(0, 4'b0010, 8, 4, 0, 0, 4'b1000);
    op(0, 4'b0010, 8, 3, 1, 0, 4'b0000);
    op(0, 4'b0001, 1, 15, 0, 0, 4'b1000);
    op(0, 4'b0000, 7, 7, 0, 0, 4'b1000);
    op(0, 4'b0101, 12, 10, 8, 0, 4'b0100);
    op(0, 4'b0100, 1, 2, 3, 0, 4'b0000);
    op(0, 4'b0110, 3, 1, 2, 0, 4'b0000);
    op(0, 4'b0100, 4, 8, 12, 0, 4'b0100);
    idle(0);
    @(negedge clk);
    chk("hold4_ack", k4, 0);
    chk("hold4_res", r4, 12);
`ifdef ALU_MUL_EN
    op(0, 4'b0011, 13, 11, 8'h0F, 8'h08, 4'b0100);
    wait_ack(0, 1, nb4);
    chk("mul4_busy_cycles", nb4, 4);
    chk("mul4_ack", k4, 1);
    chk("mul4_busy_at_ack", bz4, 0);
    @(negedge clk);
    chk("mul4_ack_pulse", k4, 0);
    chk("mul4_hi_held", h4, 8);
    op(0, 4'b0011, 2, 3, 6, 0, 4'b0000);
    wait_ack(0, 0, nb4);
    issue(0, 4'b1000, 1, 1, 2, 0, 4'b0000);
    idle(0);
    @(negedge clk);
    en4 = 1'b1; s4 = 4'b0011; a4 = 13; b4 = 11;
    @(negedge clk); en4 = 1'b0;
    @(negedge clk);
    chk("midmul4_busy", bz4, 1);
    #2 rst4_n = 1'b0;
    #1 chk("midmul_reset4", {r4, h4, z4, n4, c4, v4, bz4, k4}, 0);
`else
    op(0, 4'b0011, 5, 5, 0, 0, 4'b1000);
    op(0, 4'b0100, 5, 2, 7, 0, 4'b0000);
    idle(0);
    @(negedge clk);
    #2 rst4_n = 1'b0;
    #1 chk("reset4_again", {r4, h4, z4, n4, c4, v4, bz4, k4}, 0);
`endif
    @(negedge clk); rst4_n = 1'b1;
    op(0, 4'b1000, 2, 3, 5, 0, 4'b0000);
    idle(0);
    @(negedge clk); @(negedge clk);
  endtask
  task automatic seq8();
    #1 rst8_n = 1'b0;
    #1 chk("reset8", {r8, h8, z8, n8, c8, v8, bz8, k8}, 0);
    @(negedge clk); @(negedge clk); rst8_n = 1'b1;
    op(1, 4'b1000, 8'h90, 8'h80, 8'h10, 0, 4'b0011);
    op(1, 4'b1100, 3, 5, 8'hFE, 0, 4'b0110);
    op(1, 4'b1001, 8'h7F, 1, 8'h80, 0, 4'b0101);
    op(1, 4'b0111, 8'hFF, 8'hFF, 0, 0, 4'b1000);
    op(1, 4'b0001, 3, 2, 8'h0C, 0, 4'b0000);
    op(1, 4'b0010, 8'h80, 8, 0, 0, 4'b1000);
    op(1, 4'b0010, 8'h80, 7, 1, 0, 4'b0000);
    idle(1);
`ifdef ALU_MUL_EN
    op(1, 4'b0011, 200, 150, 8'h30, 8'h75, 4'b0000);
    wait_ack(1, 1, nb8);
    chk("mul8_busy_cycles", nb8, 8);
    chk("mul8_ack", k8, 1);
    @(negedge clk);
    chk("mul8_ack_pulse", k8, 0);
    op(1, 4'b0110, 8'hF0, 8'h0F, 8'hFF, 0, 4'b0100);
    idle(1);
`else
    op(1, 4'b0011, 5, 5, 0, 0, 4'b1000);
    idle(1);
`endif
    @(negedge clk); @(negedge clk);
  endtask
  initial begin
    fork
      seq4();
      seq8();
    join
    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);
`ifndef ALU_MUL_EN
    chk("busy4_never", saw_busy4, 0);
    chk("busy8_never", saw_busy8, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
